branch_target_buffer: RTL and testbench

- Direct-mapped BHT/BTB storage that sits upstream of the EX-stage 2-bit predictor update logic.
- At IF it looks up the fetch PC and supplies the predicted next PC.
- It carries each lookup's 2-bit counter and hit flag down to EX through IF/ID and ID/EX holding registers; these become the old counter value fed to the update logic.
- It accepts the updated counter and target written back from EX.

---
 rtl/branch_target_buffer_pkg.sv | 25 ++
 rtl/branch_target_buffer_if.sv | 34 +++
 rtl/branch_target_buffer_pipe_reg.sv | 32 +++
 rtl/branch_target_buffer.sv | 121 ++++++++++++
 tb/tb_branch_target_buffer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer and the EX-stage
// predictor update logic: 2-bit counter encodings, entry field widths
// and the per-lookup record carried down the pipeline.
package branch_target_buffer_pkg;

   localparam int PC_W      = 32;
   localparam int BHT_W     = 2;
   localparam int IDX_W_DEF = 5;

   // Saturating counter states; bit 1 is the taken/not-taken decision.
   typedef enum logic [BHT_W-1:0] {
      BHT_SNT = 2'b00,
      BHT_WNT = 2'b01,
      BHT_WT  = 2'b10,
      BHT_ST  = 2'b11
   } bht_e;

   // Lookup result travelling IF -> ID -> EX.
   typedef struct packed {
      logic             hit;
      logic             pred_taken;
      logic [BHT_W-1:0] bht;
   } bt_lookup_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch/lookup, pipeline-control and EX write-back signals of the BTB.
//   master : pipeline side (drives fetch PC, stalls/flushes, EX update)
//   slave  : BTB side (returns IF prediction and EX-stage lookup record)
interface branch_target_buffer_if;
   import branch_target_buffer_pkg::*;

   logic [PC_W-1:0]  pc_if;
   logic             stall_if_id;
   logic             stall_id_ex;
   logic             flush_id;
   logic             flush_ex;
   logic             pred_taken_if;
   logic [PC_W-1:0]  pred_next_pc_if;
   logic             hit_ex;
   logic             pred_taken_ex;
   logic [BHT_W-1:0] old_bht_ex;
   logic             upd_en_ex;
   logic [PC_W-1:0]  upd_pc_ex;
   logic [BHT_W-1:0] nex_bht_ex;
   logic [PC_W-1:0]  new_pred_ex;

   modport master (
      output pc_if, stall_if_id, stall_id_ex, flush_id, flush_ex,
             upd_en_ex, upd_pc_ex, nex_bht_ex, new_pred_ex,
      input  pred_taken_if, pred_next_pc_if, hit_ex, pred_taken_ex, old_bht_ex
   );

   modport slave (
      input  pc_if, stall_if_id, stall_id_ex, flush_id, flush_ex,
             upd_en_ex, upd_pc_ex, nex_bht_ex, new_pred_ex,
      output pred_taken_if, pred_next_pc_if, hit_ex, pred_taken_ex, old_bht_ex
   );

endinterface

// File: rtl/branch_target_buffer_pipe_reg.sv
// Holding register for one lookup record between pipeline stages.
//   clk, rst : clock, synchronous active-high reset
//   flush    : load an empty record (beats stall)
//   stall    : hold current record
//   d / q    : incoming / held lookup record
module bt_pipe_reg
   import branch_target_buffer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       stall,
   input  bt_lookup_t d,
   output bt_lookup_t q
);

   bt_lookup_t q_q, q_d;

   always_comb begin
      q_d = d;
      if (flush)      q_d = '0;
      else if (stall) q_d = q_q;
   end

   always_ff @(posedge clk) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BHT/BTB. Looks up the fetch PC combinationally to give the
// next fetch PC, carries each lookup's {hit, pred_taken, counter} to EX
// through IF/ID and ID/EX registers, and accepts EX write-backs.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of branch_target_buffer_if (fetch, stall/flush,
//              EX-stage lookup record, EX update strobe/PC/counter/target)
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int TAG_W = PC_W - IDX_W - 2
) (
   input  logic                   clk,
   input  logic                   rst,
   branch_target_buffer_if.slave  bus
);

   localparam int DEPTH = 1 << IDX_W;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [TAG_W-1:0] tag_d    [DEPTH];
   logic [PC_W-1:0]  target_q [DEPTH];
   logic [PC_W-1:0]  target_d [DEPTH];
   logic [BHT_W-1:0] bht_q    [DEPTH];
   logic [BHT_W-1:0] bht_d    [DEPTH];

   logic [IDX_W-1:0] lk_idx, upd_idx;
   logic [TAG_W-1:0] lk_tag, upd_tag;
   logic             upd_en;
   logic             lk_hit;
   logic [BHT_W-1:0] lk_bht;
   logic [PC_W-1:0]  lk_target;
   bt_lookup_t       lk_rec, if_id, id_ex;

   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{bus.pc_if[1:0], bus.upd_pc_ex[1:0]};

   assign lk_idx  = bus.pc_if[IDX_W+1:2];
   assign lk_tag  = bus.pc_if[PC_W-1:IDX_W+2];
   assign upd_idx = bus.upd_pc_ex[IDX_W+1:2];
   assign upd_tag = bus.upd_pc_ex[PC_W-1:IDX_W+2];
   // A write during reset is dropped, so it must not be forwarded either.
   assign upd_en  = bus.upd_en_ex && !rst;

   // Table write: always allocate/replace, no tag check.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      bht_d    = bht_q;
      if (upd_en) begin
         valid_d[upd_idx]  = 1'b1;
         tag_d[upd_idx]    = upd_tag;
         target_d[upd_idx] = bus.new_pred_ex;
         bht_d[upd_idx]    = bus.nex_bht_ex;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            bht_q[i]    <= BHT_SNT;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         bht_q    <= bht_d;
      end
   end

   // Lookup. A same-cycle write to the fetched index overrides the stored
   // entry: it is the value the table will hold next, so its tag decides.
   always_comb begin
      lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_bht    = bht_q[lk_idx];
      lk_target = target_q[lk_idx];
      if (upd_en && (upd_idx == lk_idx)) begin
         lk_hit    = (upd_tag == lk_tag);
         lk_bht    = bus.nex_bht_ex;
         lk_target = bus.new_pred_ex;
      end
   end

   always_comb begin
      lk_rec.hit        = lk_hit;
      lk_rec.pred_taken = lk_hit && lk_bht[1];
      lk_rec.bht        = lk_hit ? lk_bht : BHT_SNT;
   end

   assign bus.pred_taken_if   = lk_rec.pred_taken;
   assign bus.pred_next_pc_if = lk_rec.pred_taken ? lk_target
                                                  : bus.pc_if + 32'd4;

   bt_pipe_reg u_if_id (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush_id),
      .stall (bus.stall_if_id),
      .d     (lk_rec),
      .q     (if_id)
   );

   bt_pipe_reg u_id_ex (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush_ex),
      .stall (bus.stall_id_ex),
      .d     (if_id),
      .q     (id_ex)
   );

   assign bus.hit_ex        = id_ex.hit;
   assign bus.pred_taken_ex = id_ex.pred_taken;
   assign bus.old_bht_ex    = id_ex.bht;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench: stimulus pushes {cycle, signal, expected} entries; a
// negedge monitor compares every entry due in the current cycle.
module tb_branch_target_buffer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_target_buffer_if bus();

   branch_target_buffer u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] exp;
   } exp_t;

   exp_t  sb[$];
   int    cyc    = 0;
   int    checks = 0;
   int    errors = 0;
   string names[5] = '{"pred_taken_if", "pred_next_pc_if", "hit_ex",
                       "pred_taken_ex", "old_bht_ex"};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(int sig);
      case (sig)
         0:       return {31'b0, bus.pred_taken_if};
         1:       return bus.pred_next_pc_if;
         2:       return {31'b0, bus.hit_ex};
         3:       return {31'b0, bus.pred_taken_ex};
         default: return {30'b0, bus.old_bht_ex};
      endcase
   endfunction

   // Monitor: compare everything due this cycle; anything overdue is an error.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            logic [31:0] act;
            act = actual(sb[i].sig);
            checks++;
            if (sb[i].cyc < cyc || act !== sb[i].exp) begin
               errors++;
               $display("FAIL %s cyc %0d: got %h want %h",
                        names[sb[i].sig], sb[i].cyc, act, sb[i].exp);
            end
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(int dc, int sig, logic [31:0] v);
      exp_t e;
      e.cyc = cyc + dc;
      e.sig = sig;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic ex_chk(int dc, logic hit, logic taken, logic [1:0] bht);
      expect_at(dc, 2, {31'b0, hit});
      expect_at(dc, 3, {31'b0, taken});
      expect_at(dc, 4, {30'b0, bht});
   endtask

   task automatic fetch_if(logic [31:0] pc, logic taken, logic [31:0] nxt);
      bus.pc_if = pc;
      expect_at(0, 0, {31'b0, taken});
      expect_at(0, 1, nxt);
   endtask

   // Full fetch: IF prediction now, EX record two edges later (no stalls).
   task automatic fetch(logic [31:0] pc, logic taken, logic [31:0] nxt,
                        logic hit, logic [1:0] bht);
      fetch_if(pc, taken, nxt);
      ex_chk(2, hit, taken, bht);
   endtask

   task automatic upd(logic en, logic [31:0] pc, logic [1:0] bht,
                      logic [31:0] tgt);
      bus.upd_en_ex   = en;
      bus.upd_pc_ex   = pc;
      bus.nex_bht_ex  = bht;
      bus.new_pred_ex = tgt;
   endtask

   initial begin
      rst             = 1'b1;
      bus.pc_if       = '0;
      bus.stall_if_id = 1'b0;
      bus.stall_id_ex = 1'b0;
      bus.flush_id    = 1'b0;
      bus.flush_ex    = 1'b0;
      upd(1'b0, 32'h0, 2'b00, 32'h0);
      step(); step();
      rst = 1'b0;

      // Reset state and a cold miss
      ex_chk(0, 1'b0, 1'b0, 2'b00);
      fetch(32'h100, 1'b0, 32'h104, 1'b0, 2'b00); step();
      // Write 0x100 weakly taken -> 0x200
      upd(1'b1, 32'h100, 2'b10, 32'h200);
      fetch(32'h104, 1'b0, 32'h108, 1'b0, 2'b00); step();
      upd(1'b0, 32'h0, 2'b00, 32'h0);
      fetch(32'h100, 1'b1, 32'h200, 1'b1, 2'b10); step();
      // Demote to weakly not-taken
      upd(1'b1, 32'h100, 2'b01, 32'h200);
      fetch(32'h108, 1'b0, 32'h10C, 1'b0, 2'b00); step();
      upd(1'b0, 32'h0, 2'b00, 32'h0);
      fetch(32'h100, 1'b0, 32'h104, 1'b1, 2'b01); step();
      // Alias 0x180 replaces 0x100 at index 0
      upd(1'b1, 32'h180, 2'b11, 32'h500);
      fetch(32'h10C, 1'b0, 32'h110, 1'b0, 2'b00); step();
      upd(1'b0, 32'h0, 2'b00, 32'h0);
      fetch(32'h100, 1'b0, 32'h104, 1'b0, 2'b00); step();
      fetch(32'h180, 1'b1, 32'h500, 1'b1, 2'b11); step();
      // Same-cycle bypass hit
      upd(1'b1, 32'h300, 2'b11, 32'h400);
      fetch(32'h300, 1'b1, 32'h400, 1'b1, 2'b11); step();
      // Same-cycle write, same index, different tag -> miss
      upd(1'b1, 32'h100, 2'b10, 32'h600);
      fetch(32'h180, 1'b0, 32'h184, 1'b0, 2'b00); step();
      // Write on another index does not disturb lookup
      upd(1'b1, 32'h104, 2'b11, 32'h700);
      fetch(32'h100, 1'b1, 32'h600, 1'b1, 2'b10); step();
      upd(1'b0, 32'h0, 2'b00, 32'h0);
      // PC + 4 wraps
      fetch(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 2'b00); step();
      fetch(32'h104, 1'b1, 32'h700, 1'b1, 2'b11); step();

      // ID/EX stall for two cycles holds old_bht_ex
      fetch_if(32'h100, 1'b1, 32'h600); step();
      fetch_if(32'h108, 1'b0, 32'h10C); step();
      bus.stall_id_ex = 1'b1;
      fetch_if(32'h10C, 1'b0, 32'h110); ex_chk(0, 1'b1, 1'b1, 2'b10); step();
      fetch_if(32'h104, 1'b1, 32'h700); ex_chk(0, 1'b1, 1'b1, 2'b10); step();
      bus.stall_id_ex = 1'b0;
      fetch_if(32'h110, 1'b0, 32'h114); ex_chk(0, 1'b1, 1'b1, 2'b10); step();
      // IF/ID kept advancing: EX now sees the fetch from the last stall cycle
      ex_chk(0, 1'b1, 1'b1, 2'b11);
      // Flush wins over stall
      bus.flush_ex    = 1'b1;
      bus.stall_id_ex = 1'b1;
      fetch_if(32'h100, 1'b1, 32'h600); step();
      bus.flush_ex    = 1'b0;
      bus.stall_id_ex = 1'b0;
      ex_chk(0, 1'b0, 1'b0, 2'b00);
      bus.flush_id = 1'b1;
      fetch_if(32'h104, 1'b1, 32'h700); step();
      bus.flush_id = 1'b0;
      ex_chk(0, 1'b1, 1'b1, 2'b10);
      fetch_if(32'h108, 1'b0, 32'h10C); step();
      ex_chk(0, 1'b0, 1'b0, 2'b00); step();

      // Mid-run reset with a write strobe that must be ignored
      rst = 1'b1;
      upd(1'b1, 32'h104, 2'b11, 32'h700);
      step();
      rst = 1'b0;
      upd(1'b0, 32'h0, 2'b00, 32'h0);
      ex_chk(0, 1'b0, 1'b0, 2'b00);
      fetch(32'h100, 1'b0, 32'h104, 1'b0, 2'b00); step();
      fetch(32'h104, 1'b0, 32'h108, 1'b0, 2'b00); step();
      fetch(32'h180, 1'b0, 32'h184, 1'b0, 2'b00); step();
      step(); step();

      // Bounded drain of the scoreboard
      for (int i = 0; i < 10 && sb.size() != 0; i++) step();
      if (sb.size() != 0) begin
         $display("FAIL drain: got %0d pending want 0", sb.size());
         errors += sb.size();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
